// File: rtl/me_pkg.sv
// ============================================================================
// Module      : me_pkg
// Description : Shared sizing defaults and FSM encoding for the SAD engine.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package me_pkg;

    localparam int DEF_DW  = 8;
    localparam int DEF_AW  = 6;
    localparam int DEF_IDW = 6;
    localparam int ACCW    = 16;

    // Quad byte order: A=[4*DW-1:3*DW], B, C, D=[DW-1:0]; lane 0 is A.
    localparam int QUAD_LANES = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/quad_absdiff.sv
// ============================================================================
// Module      : quad_absdiff
// Description : Registered per-lane |tb - sw| for one 2x2 quad, plus a
//               combinational adder tree over the four differences.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module quad_absdiff
    import me_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*DW-1:0]   i_tb_data,
    input  logic [4*DW-1:0]   i_sw_data,
    output logic [DW+1:0]     o_diff_sum
);

    logic [QUAD_LANES-1:0][DW-1:0] w_abs;
    logic [QUAD_LANES-1:0][DW-1:0] r_diff;

    always_comb begin
        w_abs = '0;
        for (int k = 0; k < QUAD_LANES; k++) begin
            logic [DW-1:0] w_a;
            logic [DW-1:0] w_b;
            w_a = i_tb_data[(QUAD_LANES-1-k)*DW +: DW];
            w_b = i_sw_data[(QUAD_LANES-1-k)*DW +: DW];
            w_abs[k] = (w_a > w_b) ? (w_a - w_b) : (w_b - w_a);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff <= '0;
        end else begin
            r_diff <= w_abs;
        end
    end

    assign o_diff_sum = ({2'b00, r_diff[0]} + {2'b00, r_diff[1]})
                      + ({2'b00, r_diff[2]} + {2'b00, r_diff[3]});

endmodule

`default_nettype wire

// File: rtl/sad_quad_engine.sv
// ============================================================================
// Module      : sad_quad_engine
// Description : Scans 64 TB/SW quads, accumulates SAD per run and tracks the
//               minimum SAD and its candidate id across runs.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sad_quad_engine
    import me_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int AW  = DEF_AW,
    parameter int IDW = DEF_IDW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDW-1:0]    cand_id,
    input  logic              clr_best,
    output logic [AW-1:0]     tb_addr,
    output logic [AW-1:0]     sw_addr,
    input  logic [4*DW-1:0]   tb_data,
    input  logic [4*DW-1:0]   sw_data,
    output logic              busy,
    output logic              done,
    output logic [ACCW-1:0]   sad,
    output logic [IDW-1:0]    sad_id,
    output logic [ACCW-1:0]   best_sad,
    output logic [IDW-1:0]    best_id
);

    localparam logic [AW-1:0] C_LAST_ADDR = {AW{1'b1}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_addr;
    logic              r_drain_cnt;
    logic              r_rd_vld;
    logic              r_s1_vld;
    logic [ACCW-1:0]   r_acc;
    logic [ACCW-1:0]   w_acc_nxt;
    logic [IDW-1:0]    r_id;
    logic [ACCW-1:0]   r_sad;
    logic [IDW-1:0]    r_sad_id;
    logic [ACCW-1:0]   r_best_sad;
    logic [IDW-1:0]    r_best_id;
    logic [DW+1:0]     w_diff_sum;

    quad_absdiff #(
        .DW (DW)
    ) u_quad_absdiff (
        .clk        (clk),
        .rst        (rst),
        .i_tb_data  (tb_data),
        .i_sw_data  (sw_data),
        .o_diff_sum (w_diff_sum)
    );

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_DONE);
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (r_addr == C_LAST_ADDR) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_drain_cnt) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Only quads whose read data passed through stage 1 during a run are summed.
    assign w_acc_nxt = r_acc + (r_s1_vld ? ACCW'(w_diff_sum) : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_drain_cnt <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_s1_vld    <= 1'b0;
            r_acc       <= '0;
            r_id        <= '0;
            r_sad       <= '0;
            r_sad_id    <= '0;
            r_best_sad  <= '1;
            r_best_id   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rd_vld <= (r_state == S_RUN);
            r_s1_vld <= r_rd_vld;
            r_acc    <= w_acc_nxt;

            if (r_state == S_IDLE && start) begin
                r_addr <= '0;
                r_acc  <= '0;
                r_id   <= cand_id;
            end else if (r_state == S_RUN) begin
                r_addr <= r_addr + 1'b1;
            end

            r_drain_cnt <= (r_state == S_DRAIN) ? ~r_drain_cnt : 1'b0;

            // Last accumulation lands on the same edge that enters DONE.
            if (r_state == S_DRAIN && r_drain_cnt) begin
                r_sad    <= w_acc_nxt;
                r_sad_id <= r_id;
            end

            if (clr_best) begin
                r_best_sad <= '1;
                r_best_id  <= '0;
            end else if (r_state == S_DONE && r_sad < r_best_sad) begin
                r_best_sad <= r_sad;
                r_best_id  <= r_sad_id;
            end
        end
    end

    assign tb_addr  = r_addr;
    assign sw_addr  = r_addr;
    assign sad      = r_sad;
    assign sad_id   = r_sad_id;
    assign best_sad = r_best_sad;
    assign best_id  = r_best_id;

endmodule

`default_nettype wire

// File: tb/tb_sad_quad_engine.sv
// ============================================================================
// Module      : tb_sad_quad_engine
// Description : Directed self-checking bench for sad_quad_engine.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sad_quad_engine;

    localparam int DW  = 8;
    localparam int AW  = 6;
    localparam int IDW = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [IDW-1:0]  cand_id;
    logic            clr_best;
    logic [AW-1:0]   tb_addr;
    logic [AW-1:0]   sw_addr;
    logic [31:0]     tb_data;
    logic [31:0]     sw_data;
    logic            busy;
    logic            done;
    logic [15:0]     sad;
    logic [IDW-1:0]  sad_id;
    logic [15:0]     best_sad;
    logic [IDW-1:0]  best_id;

    logic [31:0]     tb_mem [64];
    logic [31:0]     sw_mem [64];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tb_data <= tb_mem[tb_addr];
        sw_data <= sw_mem[sw_addr];
    end

    sad_quad_engine #(
        .DW  (DW),
        .AW  (AW),
        .IDW (IDW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cand_id  (cand_id),
        .clr_best (clr_best),
        .tb_addr  (tb_addr),
        .sw_addr  (sw_addr),
        .tb_data  (tb_data),
        .sw_data  (sw_data),
        .busy     (busy),
        .done     (done),
        .sad      (sad),
        .sad_id   (sad_id),
        .best_sad (best_sad),
        .best_id  (best_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] tv, input logic [31:0] sv);
        for (int i = 0; i < 64; i++) begin
            tb_mem[i] = tv;
            sw_mem[i] = sv;
        end
    endtask

    task automatic fill_rand_same();
        for (int i = 0; i < 64; i++) begin
            tb_mem[i] = $urandom & 32'h7f7f7f7f;
            sw_mem[i] = tb_mem[i];
        end
    endtask

    // Returns in cycle 68 (or after timeout); latency counts cycles start->done.
    task automatic run(input logic [IDW-1:0] id, input bit clr_on_done,
                       output int lat, output int busy_cyc,
                       output logic [15:0] s, output logic [IDW-1:0] sid);
        cand_id  = id;
        start    = 1'b1;
        busy_cyc = 0;
        tick();
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 200) begin
            if (busy) busy_cyc++;
            tick();
            lat++;
        end
        if (busy) busy_cyc++;
        s   = sad;
        sid = sad_id;
        if (clr_on_done) clr_best = 1'b1;
        tick();
        clr_best = 1'b0;
    endtask

    initial begin
        int            lat;
        int            bcyc;
        int            ndone;
        int            dcyc [3];
        logic [15:0]   s;
        logic [IDW-1:0] sid;
        logic [31:0]   delta;

        rst      = 1'b1;
        start    = 1'b0;
        clr_best = 1'b0;
        cand_id  = '0;
        fill(32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        chk("reset_busy",     busy,     0);
        chk("reset_done",     done,     0);
        chk("reset_tb_addr",  tb_addr,  0);
        chk("reset_sad",      sad,      0);
        chk("reset_sad_id",   sad_id,   0);
        chk("reset_best_sad", best_sad, 32'hFFFF);
        chk("reset_best_id",  best_id,  0);

        // Identical content
        fill_rand_same();
        run(6'd3, 1'b0, lat, bcyc, s, sid);
        chk("ident_latency",  lat,      67);
        chk("ident_busy_cyc", bcyc,     67);
        chk("ident_sad",      s,        0);
        chk("ident_sad_id",   sid,      3);
        chk("ident_best_sad", best_sad, 0);
        chk("ident_best_id",  best_id,  3);
        chk("ident_idle",     busy,     0);

        // Worst case, no wrap
        fill(32'hFFFFFFFF, 32'h0);
        run(6'd9, 1'b0, lat, bcyc, s, sid);
        chk("max_sad",      s,        65280);
        chk("max_sad_id",   sid,      9);
        chk("max_best_sad", best_sad, 0);

        // Single +10 offset at addr 5 in each bank (A, B, C, D)
        for (int b = 0; b < 4; b++) begin
            fill_rand_same();
            delta = 32'd10 << (8 * (3 - b));
            sw_mem[5] = tb_mem[5] + delta;
            run(6'd4, 1'b0, lat, bcyc, s, sid);
            chk($sformatf("bank%0d_sad", b), s, 10);
        end

        // Best tracking with a tie and a coincident clear
        clr_best = 1'b1;
        tick();
        clr_best = 1'b0;
        chk("clr_best_sad", best_sad, 32'hFFFF);
        chk("clr_best_id",  best_id,  0);

        fill(32'h0, 32'h0);
        sw_mem[0] = {8'd250, 8'd250, 8'd0, 8'd0};
        run(6'd1, 1'b0, lat, bcyc, s, sid);
        chk("r1_sad",      s,        500);
        chk("r1_best_sad", best_sad, 500);
        chk("r1_best_id",  best_id,  1);
        sw_mem[0] = {8'd150, 8'd0, 8'd150, 8'd0};
        run(6'd2, 1'b0, lat, bcyc, s, sid);
        chk("r2_best_sad", best_sad, 300);
        chk("r2_best_id",  best_id,  2);
        run(6'd3, 1'b0, lat, bcyc, s, sid);
        chk("r3_sad",      s,        300);
        chk("r3_best_sad", best_sad, 300);
        chk("r3_best_id",  best_id,  2);
        sw_mem[0] = {8'd0, 8'd100, 8'd0, 8'd100};
        run(6'd5, 1'b1, lat, bcyc, s, sid);
        chk("r4_sad",      s,        200);
        chk("r4_best_sad", best_sad, 32'hFFFF);
        chk("r4_best_id",  best_id,  0);

        // Reset mid-run at cycle 30
        fill(32'hFFFFFFFF, 32'h0);
        cand_id = 6'd7;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 30; c++) tick();
        chk("mid_tb_addr", tb_addr, 29);
        chk("mid_sw_addr", sw_addr, 29);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy",    busy,    0);
        chk("abort_tb_addr", tb_addr, 0);
        chk("abort_sad",     sad,     0);
        ndone = 0;
        for (int c = 0; c < 80; c++) begin
            if (done) ndone++;
            tick();
        end
        chk("abort_no_done", ndone, 0);
        run(6'd8, 1'b0, lat, bcyc, s, sid);
        chk("post_latency",  lat,      67);
        chk("post_sad",      s,        65280);
        chk("post_best_sad", best_sad, 65280);
        chk("post_best_id",  best_id,  8);

        // Start held high: one run per 68 cycles, no queuing
        fill(32'h0, 32'h0);
        cand_id = 6'd2;
        start   = 1'b1;
        ndone   = 0;
        dcyc    = '{0, 0, 0};
        for (int c = 1; c <= 210; c++) begin
            tick();
            if (done) begin
                if (ndone < 3) dcyc[ndone] = c;
                ndone++;
            end
        end
        start = 1'b0;
        chk("hold_ndone", ndone,   3);
        chk("hold_done0", dcyc[0], 67);
        chk("hold_done1", dcyc[1], 135);
        chk("hold_done2", dcyc[2], 203);
        for (int c = 0; c < 80 && busy; c++) tick();
        chk("hold_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sad_quad_engine.md
# sad_quad_engine

Downstream consumer of the 4-bank template-block memory. Each run scans all 64 quad addresses of a 16x16 template block (TB) and the matching search-window (SW) candidate block. Every word carries one 2x2 pixel quad, packed {A,B,C,D}. The block accumulates the sum of absolute differences (SAD) over the 256 pixels and tracks the minimum SAD, and its candidate id, across successive runs.

## Interface
Parameters:
- DW, 8: pixel width.
- AW, 6: quad address width (64 quads).
- IDW, 6: candidate id width.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  run request; sampled only in IDLE.
- cand_id  in  IDW  candidate id; latched when start is accepted.
- clr_best  in  1  one-cycle pulse; re-initialises the best-SAD tracker.
- tb_addr  out  AW  quad address to the TB memory port A; registered.
- sw_addr  out  AW  quad address to the SW memory; always equal to tb_addr.
- tb_data  in  4*DW  TB quad {A,B,C,D}; 1-cycle synchronous read latency.
- sw_data  in  4*DW  SW quad {A,B,C,D}; same latency.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; sad is valid in the same cycle.
- sad  out  16  SAD of the last completed run; held until the next done.
- sad_id  out  IDW  cand_id of the last completed run.
- best_sad  out  16  minimum SAD since the last clr_best or reset.
- best_id  out  IDW  cand_id that produced best_sad.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE to RUN when start=1. On that edge: address counter cleared, accumulator cleared, cand_id latched.
  - RUN lasts 64 cycles. tb_addr steps 0..63, incrementing by 1 per cycle. After the cycle with address 63, go to DRAIN.
  - DRAIN lasts 2 cycles and flushes the read and abs-diff pipeline.
  - DONE lasts 1 cycle with done=1, then returns to IDLE.
- Datapath:
  - Stage 1: four registered |tb_k - sw_k|, each DW bits.
  - Stage 2: the four diffs are summed into a DW+2 bit value and added into a 16-bit accumulator.
  - Worst case is 64*4*255 = 65280, so no overflow and no saturation logic.
- Pipeline-valid bit:
  - Stage-1 valid is set one cycle after each RUN address cycle.
  - Stage-2 accumulates only when stage-1 valid is set.
  - Idle bus values never enter the sum.
- Best tracking:
  - At the DONE edge, if sad < best_sad (strict), load best_sad and best_id.
  - On a tie the earlier candidate is kept.
  - clr_best sets best_sad=16'hFFFF and best_id=0.
  - If clr_best and a DONE update coincide, clr_best wins and the current run's result is excluded from best.
- start is ignored outside IDLE and is not queued.
- Reset values: state IDLE, tb_addr=0, busy=0, done=0, sad=0, sad_id=0, best_sad=16'hFFFF, best_id=0, accumulator and pipeline valid bits 0.
- Reset mid-run aborts the run: no done pulse, sad keeps its reset value, best is untouched except by the reset itself.

## Timing
- Cycle 0: start=1 in IDLE.
- Cycles 1..64: RUN; tb_addr = cycle-1.
- Cycles 2..65: tb_data and sw_data valid.
- Cycles 3..66: stage-1 diffs valid; each accumulates at the end of its cycle.
- Cycle 67: DONE; done=1, sad and sad_id valid.
- Cycle 68: best_sad and best_id reflect the run. IDLE; earliest accepted start.
- Start-to-done latency is 67 cycles; back-to-back throughput is one run per 68 cycles.
- busy is 1 in cycles 1..67.

## Structure
- Shared package me_pkg holds:
  - DW and AW defaults, the derived ACCW=16, and the FSM state encoding.
  - Quad byte order: A=[31:24], B=[23:16], C=[15:8], D=[7:0].
- One sub-module, quad_absdiff: four registered absolute differences plus a combinational 4-input adder tree with a DW+2 bit output.
- The FSM, counter, accumulator and best tracker live in the top level.

## Test plan
- TB and SW memories identical random content, cand_id=3 -> done at cycle 67 with sad=0, sad_id=3; best_sad=0, best_id=3 at cycle 68.
- TB all 8'hFF, SW all 8'h00 -> sad=65280, no wrap.
- SW equals TB except bank C at addr 5, which is +10 -> sad=10. Repeat with the offset in bank A, B and D in turn -> sad=10 each time.
- Three runs: ids 1, 2, 3 with sad 500, 300, 300 -> best_sad=300, best_id=2. Then clr_best on the DONE cycle of a 200-SAD run -> best_sad=16'hFFFF, best_id=0.
- Assert rst at cycle 30 of a run -> next cycle IDLE, busy=0, tb_addr=0; no done. A subsequent start completes normally 67 cycles later.
- Hold start high continuously -> runs start at cycles 0, 68, 136. Starts during busy are not queued, and exactly one done occurs per 68 cycles.
